// File: rtl/kronos_mem_arbiter.sv
// kronos_mem_arbiter
// Shares one single-ported memory bus between the instruction fetch port (I)
// and the load/store port (D). D has fixed priority. Once a request is
// presented and not granted in the same cycle, the bus is locked to that port
// until mem_gnt (or until the port drops its request), so address and write
// data stay stable for the whole transaction.
//
// Optional build macro KRONOS_ARB_STARVE_EN: adds a saturating wait counter
// that gives I priority over D in IDLE after MAX_WAIT consecutive denied
// cycles. Without the macro, strict D-over-I priority applies.
module kronos_mem_arbiter #(
  parameter int MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr_addr,
  input  logic        instr_req,
  output logic        instr_gnt,
  output logic [31:0] instr_data,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  input  logic [3:0]  data_mask,
  input  logic        data_wr_en,
  input  logic        data_req,
  output logic        data_gnt,
  output logic [31:0] data_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_mask,
  output logic        mem_wr_en,
  output logic        mem_req,
  input  logic        mem_gnt,
  input  logic [31:0] mem_rdata,
  output logic [1:0]  arb_owner
);

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] LOCK_I = 2'b01;
  localparam logic [1:0] LOCK_D = 2'b10;

  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_I    = 2'b01;
  localparam logic [1:0] OWN_D    = 2'b10;

  // A zero MAX_WAIT would make the starvation guard permanently active.
  if (MAX_WAIT < 1) begin : g_bad_max_wait
    $error("kronos_mem_arbiter: MAX_WAIT must be >= 1");
  end

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic [1:0] owner;
  logic [1:0] owner_nxt;
  logic [1:0] sel;
  logic       starve;

`ifdef KRONOS_ARB_STARVE_EN
  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] WAIT_MAX = CW'(MAX_WAIT);

  logic [CW-1:0] wait_cnt;

  assign starve = (wait_cnt == WAIT_MAX);

  // Count consecutive cycles the I-port is kept waiting; saturate at MAX_WAIT.
  always_ff @(posedge clk) begin
    if (rst || !instr_req || instr_gnt) begin
      wait_cnt <= '0;
    end else if (wait_cnt != WAIT_MAX) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end
`else
  assign starve = 1'b0;
`endif

  // Pick the bus owner: frozen while locked, priority-selected in IDLE.
  always_comb begin
    sel = OWN_NONE;
    case (state)
      LOCK_I: sel = OWN_I;
      LOCK_D: sel = OWN_D;
      default: begin
        if (starve && instr_req) begin
          sel = OWN_I;
        end else if (data_req) begin
          sel = OWN_D;
        end else if (instr_req) begin
          sel = OWN_I;
        end
      end
    endcase
  end

  // Drive the shared bus from the selected port; everything is 0 in reset or when idle.
  always_comb begin
    mem_req   = 1'b0;
    mem_addr  = 32'h0;
    mem_wdata = 32'h0;
    mem_mask  = 4'h0;
    mem_wr_en = 1'b0;
    if (!rst) begin
      if (sel == OWN_D) begin
        mem_req   = data_req;
        mem_addr  = data_addr;
        mem_wdata = data_wdata;
        mem_mask  = data_mask;
        mem_wr_en = data_wr_en;
      end else if (sel == OWN_I) begin
        mem_req   = instr_req;
        mem_addr  = instr_addr;
        mem_mask  = 4'hF;
      end
    end
  end

  // A grant only counts while a request is actually on the bus.
  assign instr_gnt  = mem_req & mem_gnt & (sel == OWN_I);
  assign data_gnt   = mem_req & mem_gnt & (sel == OWN_D);
  assign instr_data = mem_rdata;
  assign data_rdata = mem_rdata;

  // Lock on an ungranted request; report the owner of a zero-wait grant for one cycle.
  always_comb begin
    state_nxt = IDLE;
    owner_nxt = OWN_NONE;
    if (mem_req && !mem_gnt) begin
      state_nxt = (sel == OWN_D) ? LOCK_D : LOCK_I;
      owner_nxt = sel;
    end else if (mem_req && mem_gnt && (state == IDLE)) begin
      owner_nxt = sel;
    end
  end

  // State and owner registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      owner <= OWN_NONE;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
    end
  end

  assign arb_owner = rst ? OWN_NONE : owner;

endmodule

// File: tb/tb_kronos_mem_arbiter.sv
// Self-checking bench for kronos_mem_arbiter. Expected grant transactions are
// queued when stimulus is driven and popped whenever the DUT asserts a grant.
// Build with +define+KRONOS_ARB_STARVE_EN to exercise the starvation guard.
module tb_kronos_mem_arbiter;

  localparam int MW = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr_addr;
  logic        instr_req;
  logic        instr_gnt;
  logic [31:0] instr_data;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [3:0]  data_mask;
  logic        data_wr_en;
  logic        data_req;
  logic        data_gnt;
  logic [31:0] data_rdata;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_mask;
  logic        mem_wr_en;
  logic        mem_req;
  logic        mem_gnt;
  logic [31:0] mem_rdata;
  logic [1:0]  arb_owner;

  typedef struct {
    logic        is_d;
    logic [31:0] addr;
    logic [31:0] rdata;
    logic [31:0] wdata;
    logic [3:0]  mask;
    logic        wr;
  } exp_t;

  exp_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;
  int   i_grants = 0;

  kronos_mem_arbiter #(.MAX_WAIT(MW)) dut (
    .clk        (clk),
    .rst        (rst),
    .instr_addr (instr_addr),
    .instr_req  (instr_req),
    .instr_gnt  (instr_gnt),
    .instr_data (instr_data),
    .data_addr  (data_addr),
    .data_wdata (data_wdata),
    .data_mask  (data_mask),
    .data_wr_en (data_wr_en),
    .data_req   (data_req),
    .data_gnt   (data_gnt),
    .data_rdata (data_rdata),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_mask   (mem_mask),
    .mem_wr_en  (mem_wr_en),
    .mem_req    (mem_req),
    .mem_gnt    (mem_gnt),
    .mem_rdata  (mem_rdata),
    .arb_owner  (arb_owner)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      $display("FAIL %s: got 0x%08h, required 0x%08h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic push_i(input logic [31:0] a, input logic [31:0] r);
    sb.push_back('{is_d: 1'b0, addr: a, rdata: r, wdata: 32'h0, mask: 4'hF, wr: 1'b0});
  endtask

  task automatic push_d(input logic [31:0] a, input logic [31:0] r, input logic [31:0] w,
                        input logic [3:0] m, input logic wr);
    sb.push_back('{is_d: 1'b1, addr: a, rdata: r, wdata: w, mask: m, wr: wr});
  endtask

  task automatic idle_in();
    instr_req  = 1'b0;
    instr_addr = 32'h0;
    data_req   = 1'b0;
    data_addr  = 32'h0;
    data_wdata = 32'h0;
    data_mask  = 4'h0;
    data_wr_en = 1'b0;
    mem_gnt    = 1'b0;
    mem_rdata  = 32'h0;
  endtask

  // Move to the sampling point and score any grant seen there.
  task automatic sample();
    exp_t e;
    @(negedge clk);
    if (instr_gnt && data_gnt) chk("both_gnt", 32'd1, 32'd0);
    if (instr_gnt || data_gnt) begin
      if (instr_gnt) i_grants++;
      if (sb.size() == 0) begin
        chk("unexp_gnt", {30'h0, data_gnt, instr_gnt}, 32'h0);
      end else begin
        e = sb.pop_front();
        chk("gnt_port", {31'h0, data_gnt}, {31'h0, e.is_d});
        chk("gnt_addr", mem_addr, e.addr);
        chk("gnt_wdata", mem_wdata, e.wdata);
        chk("gnt_mask", {28'h0, mem_mask}, {28'h0, e.mask});
        chk("gnt_wr", {31'h0, mem_wr_en}, {31'h0, e.wr});
        chk("gnt_rdata", e.is_d ? data_rdata : instr_data, e.rdata);
      end
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    idle_in();
    sample();
    adv();
  endtask

  initial begin
    rst = 1'b1;
    idle_in();
    // Requests and a stray grant during reset must not reach the bus.
    data_req  = 1'b1;
    data_addr = 32'hAAAA_0000;
    data_wr_en = 1'b1;
    instr_req = 1'b1;
    mem_gnt   = 1'b1;
    sample();
    chk("rst_mem_req", {31'h0, mem_req}, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wr", {31'h0, mem_wr_en}, 32'h0);
    chk("rst_owner", {30'h0, arb_owner}, 32'h0);
    adv();
    sample();
    adv();
    rst = 1'b0;
    quiet();

    // Zero-wait I read.
    instr_req  = 1'b1;
    instr_addr = 32'h100;
    mem_gnt    = 1'b1;
    mem_rdata  = 32'hDEAD_BEEF;
    push_i(32'h100, 32'hDEAD_BEEF);
    sample();
    chk("zw_mem_req", {31'h0, mem_req}, 32'h1);
    chk("zw_instr_gnt", {31'h0, instr_gnt}, 32'h1);
    chk("zw_owner_pre", {30'h0, arb_owner}, 32'h0);
    adv();
    idle_in();
    sample();
    chk("zw_owner_post", {30'h0, arb_owner}, 32'h1);
    chk("idle_mem_addr", mem_addr, 32'h0);
    chk("idle_mem_mask", {28'h0, mem_mask}, 32'h0);
    adv();
    sample();
    chk("zw_owner_clr", {30'h0, arb_owner}, 32'h0);
    adv();

    // Simultaneous D write and I read: D first, then I.
    data_req   = 1'b1;
    data_wr_en = 1'b1;
    data_addr  = 32'h2000;
    data_wdata = 32'h1234_5678;
    data_mask  = 4'b0011;
    instr_req  = 1'b1;
    instr_addr = 32'h104;
    mem_gnt    = 1'b1;
    mem_rdata  = 32'h1111_1111;
    push_d(32'h2000, 32'h1111_1111, 32'h1234_5678, 4'b0011, 1'b1);
    sample();
    chk("sim_data_gnt", {31'h0, data_gnt}, 32'h1);
    adv();
    data_req   = 1'b0;
    data_wr_en = 1'b0;
    data_wdata = 32'h0;
    data_mask  = 4'h0;
    mem_rdata  = 32'h2222_2222;
    push_i(32'h104, 32'h2222_2222);
    sample();
    chk("sim_owner_d", {30'h0, arb_owner}, 32'h2);
    adv();
    quiet();
    quiet();

    // D read locked for three wait cycles while I starts requesting.
    data_req   = 1'b1;
    data_addr  = 32'h3000;
    data_mask  = 4'hF;
    mem_gnt    = 1'b0;
    sample();
    chk("lkd_addr0", mem_addr, 32'h3000);
    chk("lkd_owner0", {30'h0, arb_owner}, 32'h0);
    adv();
    instr_req  = 1'b1;
    instr_addr = 32'h108;
    for (int c = 1; c < 3; c++) begin
      sample();
      chk("lkd_addr", mem_addr, 32'h3000);
      chk("lkd_owner", {30'h0, arb_owner}, 32'h2);
      adv();
    end
    mem_gnt   = 1'b1;
    mem_rdata = 32'h3333_3333;
    push_d(32'h3000, 32'h3333_3333, 32'h0, 4'hF, 1'b0);
    sample();
    chk("lkd_addr3", mem_addr, 32'h3000);
    chk("lkd_data_gnt", {31'h0, data_gnt}, 32'h1);
    adv();
    data_req  = 1'b0;
    mem_rdata = 32'h4444_4444;
    push_i(32'h108, 32'h4444_4444);
    sample();
    chk("lkd_owner_after", {30'h0, arb_owner}, 32'h0);
    adv();
    quiet();

    // I locked while D requests: D waits for the I grant.
    instr_req  = 1'b1;
    instr_addr = 32'h200;
    mem_gnt    = 1'b0;
    sample();
    adv();
    data_req   = 1'b1;
    data_addr  = 32'h4000;
    data_mask  = 4'hF;
    sample();
    chk("lki_addr", mem_addr, 32'h200);
    chk("lki_owner", {30'h0, arb_owner}, 32'h1);
    chk("lki_mask", {28'h0, mem_mask}, 32'hF);
    adv();
    mem_gnt   = 1'b1;
    mem_rdata = 32'h5555_5555;
    push_i(32'h200, 32'h5555_5555);
    sample();
    adv();
    instr_req = 1'b0;
    mem_rdata = 32'h6666_6666;
    push_d(32'h4000, 32'h6666_6666, 32'h0, 4'hF, 1'b0);
    sample();
    adv();
    quiet();

    // Abort: I locks, then drops its request; a stray mem_gnt is ignored.
    instr_req  = 1'b1;
    instr_addr = 32'h300;
    mem_gnt    = 1'b0;
    sample();
    adv();
    instr_req  = 1'b0;
    data_req   = 1'b1;
    data_wr_en = 1'b1;
    data_addr  = 32'h5000;
    data_wdata = 32'hCAFE_F00D;
    data_mask  = 4'b1100;
    mem_gnt    = 1'b1;
    sample();
    chk("abort_mem_req", {31'h0, mem_req}, 32'h0);
    chk("abort_data_gnt", {31'h0, data_gnt}, 32'h0);
    chk("abort_owner", {30'h0, arb_owner}, 32'h1);
    adv();
    mem_rdata = 32'h7777_7777;
    push_d(32'h5000, 32'h7777_7777, 32'hCAFE_F00D, 4'b1100, 1'b1);
    sample();
    chk("abort_next_req", {31'h0, mem_req}, 32'h1);
    adv();
    idle_in();
    sample();
    chk("abort_owner_d", {30'h0, arb_owner}, 32'h2);
    adv();

    // Reset while locked on D, with a grant arriving in the reset cycle.
    data_req  = 1'b1;
    data_addr = 32'h6000;
    data_mask = 4'hF;
    mem_gnt   = 1'b0;
    sample();
    adv();
    rst     = 1'b1;
    mem_gnt = 1'b1;
    sample();
    chk("rml_mem_req", {31'h0, mem_req}, 32'h0);
    chk("rml_data_gnt", {31'h0, data_gnt}, 32'h0);
    chk("rml_owner", {30'h0, arb_owner}, 32'h0);
    chk("rml_mem_addr", mem_addr, 32'h0);
    adv();
    rst = 1'b0;
    idle_in();
    sample();
    chk("rml_owner_after", {30'h0, arb_owner}, 32'h0);
    chk("rml_req_after", {31'h0, mem_req}, 32'h0);
    adv();
    data_req  = 1'b1;
    data_addr = 32'h6004;
    data_mask = 4'hF;
    mem_gnt   = 1'b1;
    mem_rdata = 32'h8888_8888;
    push_d(32'h6004, 32'h8888_8888, 32'h0, 4'hF, 1'b0);
    sample();
    adv();
    quiet();

    // Continuous D and I requests with a grant every cycle.
    i_grants   = 0;
    data_req   = 1'b1;
    data_addr  = 32'h7000;
    data_mask  = 4'hF;
    instr_req  = 1'b1;
    instr_addr = 32'h400;
    mem_gnt    = 1'b1;
    for (int c = 0; c < 10; c++) begin
      mem_rdata = 32'h9000_0000 + c;
`ifdef KRONOS_ARB_STARVE_EN
      if ((c % (MW + 1)) == MW) push_i(32'h400, 32'h9000_0000 + c);
      else push_d(32'h7000, 32'h9000_0000 + c, 32'h0, 4'hF, 1'b0);
`else
      push_d(32'h7000, 32'h9000_0000 + c, 32'h0, 4'hF, 1'b0);
`endif
      sample();
      adv();
    end
`ifdef KRONOS_ARB_STARVE_EN
    chk("starve_i_grants", i_grants, 32'd2);
`else
    chk("starve_i_grants", i_grants, 32'd0);
`endif
    quiet();

    chk("sb_drained", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
